// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin sharing of NR_WB_PORTS write-back ports among NB_REQ held FU results.
// Optional per-requester stall counters are enabled with `define WB_ARB_STALL_CNT_EN.
package wb_arbiter_pkg;
  localparam int NB_FU = 4;
  localparam int NR_WB_PORTS = 2;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
  } fu_output_t;
endpackage

module wb_arbiter #(
  parameter int NB_REQ = wb_arbiter_pkg::NB_FU,
  parameter int NR_WB_PORTS = wb_arbiter_pkg::NR_WB_PORTS,
  parameter int CNT_W = 32
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          flush_i,
  input  wb_arbiter_pkg::fu_output_t [NB_REQ-1:0]       req_i,
  input  logic [NB_REQ-1:0]                             req_valid_i,
  output logic [NB_REQ-1:0]                             req_ready_o,
  output wb_arbiter_pkg::fu_output_t [NR_WB_PORTS-1:0]  wb_o,
  output logic [NR_WB_PORTS-1:0]                        wb_valid_o,
  output logic [NB_REQ-1:0][CNT_W-1:0]                  stall_cnt_o
);
  localparam int PTR_W = NB_REQ > 1 ? $clog2(NB_REQ) : 1;
  wb_arbiter_pkg::fu_output_t [NB_REQ-1:0] hold_q;
  logic [NB_REQ-1:0] hold_valid_q;
  logic [NB_REQ-1:0] grant;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] ptr_nxt;
  int n;
  // Scan from the pointer; the n-th granted requester drives port n.
  always_comb begin
    grant = '0;
    wb_valid_o = '0;
    wb_o = '0;
    ptr_nxt = rr_ptr_q;
    n = 0;
    for (int k = 0; k < NB_REQ; k++)
      for (int i = 0; i < NB_REQ; i++)
        if (i == (int'(rr_ptr_q) + k) % NB_REQ && hold_valid_q[i] && n < NR_WB_PORTS) begin
          grant[i] = 1'b1;
          for (int p = 0; p < NR_WB_PORTS; p++)
            if (p == n) begin
              wb_o[p] = hold_q[i];
              wb_valid_o[p] = 1'b1;
            end
          n = n + 1;
          ptr_nxt = PTR_W'((i + 1) % NB_REQ);
        end
    if (flush_i) begin
      wb_valid_o = '0;
      wb_o = '0;
    end
  end
  assign req_ready_o = flush_i ? '1 : (~hold_valid_q | grant);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_valid_q <= '0;
      rr_ptr_q <= '0;
    end else if (flush_i) begin
      hold_valid_q <= '0;
    end else begin
      for (int i = 0; i < NB_REQ; i++)
        if (req_valid_i[i] && req_ready_o[i]) hold_valid_q[i] <= 1'b1;
        else if (grant[i]) hold_valid_q[i] <= 1'b0;
      if (|grant) rr_ptr_q <= ptr_nxt;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB_REQ; i++)
      if (!flush_i && req_valid_i[i] && req_ready_o[i]) hold_q[i] <= req_i[i];
  end
`ifdef WB_ARB_STALL_CNT_EN
  logic [NB_REQ-1:0][CNT_W-1:0] stall_cnt_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NB_REQ; i++)
        if (hold_valid_q[i] && !grant[i] && !flush_i && stall_cnt_q[i] != '1)
          stall_cnt_q[i] <= stall_cnt_q[i] + 1'b1;
    end
  end
  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif
endmodule
